lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised successor to the fixed 16-bit LFSR: configurable width, tap masks and reset seed.
- Runtime selection between Fibonacci and Galois feedback.
- Runtime seed load with an all-zero lock-up guard.
- Period measurement: counts shifts since the start state, pulses on sequence wrap and latches the measured period for the display/debug path.

Parameters:
- WIDTH, 16, LFSR state width (3..32).
- FIB_TAPS, 16'hB400, Fibonacci tap mask; bit i set means q[i] feeds the XOR (x^16+x^14+x^13+x^11+1).
- GAL_POLY, 16'h6801, Galois polynomial mask for the left-shift form; bit 0 must be set.
- SEED, 16'h0001, reset state and substitute for an all-zero load; must be nonzero.
- CNT_W, 16, width of ticks/period; must be >= WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sh_en  in  1  shift enable; one state advance per cycle while high.
- load  in  1  load seed_in as new state and start state; overrides sh_en.
- seed_in  in  WIDTH  seed value for load.
- mode  in  1  0 = Fibonacci, 1 = Galois.
- q_out  out  WIDTH  current LFSR state (registered).
- ticks  out  CNT_W  shifts taken since the start state.
- max_tick  out  1  one-cycle pulse when the state returns to the start state.
- period  out  CNT_W  last measured period; 0 until the first wrap.
- lockup  out  1  one-cycle pulse when a zero seed was replaced by SEED.

Behaviour:
- Reset (async assert, sync release): q_out=SEED, start=SEED, ticks=0, period=0, max_tick=0, lockup=0, mode_q=0.
- Fibonacci next state: {q[WIDTH-2:0], ^(q & FIB_TAPS)}.
- Galois next state: {q[WIDTH-2:0],1'b0} ^ ({WIDTH{q[WIDTH-1]}} & GAL_POLY).
- Priority per cycle: load > mode change > shift > hold.
- load=1:
  - q_out and start take seed_in, or SEED if seed_in==0; in that case lockup=1 for the next cycle.
  - ticks=0; no shift that cycle; period is retained.
- Mode change: mode is registered to mode_q each cycle.
  - If sh_en=1 and mode!=mode_q, the cycle performs no shift.
  - That cycle sets start=q_out and ticks=0 (re-arms the measurement); mode_q updates.
- Shift (sh_en=1, no load, no mode change): q_out takes the next state for mode_q.
  - If next state == start: ticks=0, period=ticks+1 (saturating at all-ones), max_tick=1 in the following cycle.
  - Otherwise ticks=ticks+1, saturating at all-ones. Saturated ticks stays saturated and period is unaffected until a wrap occurs.
- sh_en=0: state, ticks and period hold; max_tick and lockup are 0.
- max_tick and lockup are registered single-cycle pulses and never held. Back-to-back wraps are only possible when period=1; in that case max_tick stays high every cycle.
- Latency: q_out, ticks, max_tick and period all update on the clock edge after the qualifying cycle.
- All-zero state is unreachable: reset and load both guard it, and both shift forms map nonzero to nonzero for valid masks.
- rst_n asserted mid-sequence: immediate return to reset values; a pending pulse is dropped.

Test Plan:
- Reset hold 5 cycles, then sh_en=1, mode=0, default parameters: q_out sequence 0001,0002,…,0400,0801; ticks=11 after the 11th shift; max_tick=0.
- mode=1 from reset: 16th shift gives q_out=6801; the mode change cycle itself does not shift; ticks=16 after the 16th shift.
- Instance WIDTH=4, FIB_TAPS=4'hC, SEED=4'h1, CNT_W=8, mode=0, continuous shift: 0001,0010,0100,1001,0011,…,1000,0001. max_tick pulses on the cycle after the 15th shift and every 15 thereafter; period=15; ticks=0 at the wrap.
- load=1 with seed_in=0: q_out=SEED, lockup pulses for one cycle. Then load with seed_in=16'hACE1 while sh_en=1: q_out=ACE1 with no shift that cycle, ticks=0, period unchanged.
- Toggle mode mid-run: no shift that cycle, ticks=0, start=current q_out. WIDTH=4 Galois run then gives max_tick after 15 shifts and period=15.
- Assert rst_n low mid-run on a cycle where max_tick would pulse: outputs return immediately to reset values and no max_tick pulse appears after release.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if
//   Control/status bundle for the lfsr_gen block. The master side (the user of
//   the generator) drives the shift/load/mode controls and the seed; the slave
//   side (lfsr_gen) returns the registered state and the period-measurement
//   results.
//
//   Signals:
//     sh_en    shift enable, one state advance per cycle while high
//     load     load seed_in as the new state and start state
//     seed_in  seed value used by load (WIDTH bits)
//     mode     feedback form select, 0 = Fibonacci, 1 = Galois
//     q_out    current LFSR state (WIDTH bits)
//     ticks    shifts taken since the start state (CNT_W bits)
//     max_tick one-cycle pulse when the state returns to the start state
//     period   last measured period, 0 until the first wrap (CNT_W bits)
//     lockup   one-cycle pulse when a zero seed was replaced by the reset seed
interface lfsr_gen_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic             sh_en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             mode;
  logic [WIDTH-1:0] q_out;
  logic [CNT_W-1:0] ticks;
  logic             max_tick;
  logic [CNT_W-1:0] period;
  logic             lockup;

  modport master (
    output sh_en, load, seed_in, mode,
    input  q_out, ticks, max_tick, period, lockup
  );

  modport slave (
    input  sh_en, load, seed_in, mode,
    output q_out, ticks, max_tick, period, lockup
  );

endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen
//   Parametrised linear feedback shift register with runtime selection between
//   Fibonacci and Galois feedback, a guarded seed load and a period meter.
//   The period meter counts shifts since the "start" state (the last loaded
//   seed, the reset seed, or the state at which the feedback mode was last
//   switched) and latches the count when the sequence comes back to it.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset, synchronous release expected
//     bus    lfsr_gen_if slave modport carrying sh_en, load, seed_in, mode
//            (inputs) and q_out, ticks, max_tick, period, lockup (outputs)
//
//   Parameters:
//     WIDTH     state width, 3..32
//     FIB_TAPS  Fibonacci tap mask, bit i set means state bit i feeds the XOR
//     GAL_POLY  Galois polynomial mask for the left-shift form, bit 0 set
//     SEED      reset state and replacement for an all-zero load, nonzero
//     CNT_W     width of ticks/period, at least WIDTH
module lfsr_gen #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] GAL_POLY = 16'h6801,
  parameter logic [WIDTH-1:0] SEED     = 16'h0001,
  parameter int               CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  lfsr_gen_if.slave   bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [CNT_W-1:0] ticks;
  logic [CNT_W-1:0] period;
  logic             max_tick;
  logic             lockup;
  logic             mode_q;

  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] load_value;
  logic             seed_zero;
  logic             mode_change;
  logic [CNT_W-1:0] ticks_inc;

  // Both feedback forms are computed every cycle; the registered mode picks
  // one. A mode switch is only acted on through mode_q, so the switch cycle
  // itself never shifts with a half-changed feedback selection.
  assign fib_next   = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
  assign gal_next   = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & GAL_POLY);
  assign shift_next = mode_q ? gal_next : fib_next;

  // An all-zero seed would lock the register up forever, so it is swapped for
  // the reset seed and flagged.
  assign seed_zero   = (bus.seed_in == '0);
  assign load_value  = seed_zero ? SEED : bus.seed_in;
  assign mode_change = bus.sh_en && (bus.mode != mode_q);

  // Saturating increment shared by the running tick count and the latched
  // period, so a sequence longer than the counter reports all-ones.
  assign ticks_inc = (ticks == '1) ? ticks : ticks + CNT_W'(1);

  // Priority per cycle: load, then mode change, then shift, else hold.
  // Pulse outputs default low every cycle so they can never be held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEED;
      start    <= SEED;
      ticks    <= '0;
      period   <= '0;
      max_tick <= 1'b0;
      lockup   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      mode_q   <= bus.mode;
      max_tick <= 1'b0;
      lockup   <= 1'b0;
      if (bus.load) begin
        state  <= load_value;
        start  <= load_value;
        ticks  <= '0;
        lockup <= seed_zero;
      end else if (mode_change) begin
        // Re-arm the period meter from wherever the sequence currently is,
        // since the new feedback form walks a different cycle.
        start <= state;
        ticks <= '0;
      end else if (bus.sh_en) begin
        state <= shift_next;
        if (shift_next == start) begin
          ticks    <= '0;
          period   <= ticks_inc;
          max_tick <= 1'b1;
        end else begin
          ticks <= ticks_inc;
        end
      end
    end
  end

  assign bus.q_out    = state;
  assign bus.ticks    = ticks;
  assign bus.period   = period;
  assign bus.max_tick = max_tick;
  assign bus.lockup   = lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen
//   Scoreboard bench for lfsr_gen. Two instances run side by side: index 0 is
//   the default 16-bit generator, index 1 is a 4-bit generator (taps 4'hC,
//   Galois polynomial 4'h3, seed 1, 8-bit counters). Each cycle the driver
//   applies inputs on the falling edge, advances a behavioural model and
//   pushes the expected post-edge outputs; a monitor pops and compares them
//   one time unit after every rising edge.
module tb_lfsr_gen;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] ticks;
    logic [31:0] period;
    logic        max_tick;
    logic        lockup;
  } exp_t;

  logic clk;
  logic rst_n;

  lfsr_gen_if #(.WIDTH(16), .CNT_W(16)) bus_a ();
  lfsr_gen_if #(.WIDTH(4),  .CNT_W(8))  bus_b ();

  lfsr_gen dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  lfsr_gen #(
    .WIDTH    (4),
    .FIB_TAPS (4'hC),
    .GAL_POLY (4'h3),
    .SEED     (4'h1),
    .CNT_W    (8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Per-instance configuration seen by the reference model.
  int          m_w    [2] = '{16, 4};
  int          m_cw   [2] = '{16, 8};
  logic [31:0] m_taps [2] = '{32'hB400, 32'hC};
  logic [31:0] m_poly [2] = '{32'h6801, 32'h3};
  logic [31:0] m_seed [2] = '{32'h1, 32'h1};

  // Reference model state.
  logic [31:0] m_q      [2];
  logic [31:0] m_start  [2];
  logic [31:0] m_ticks  [2];
  logic [31:0] m_period [2];
  logic        m_modeq  [2];
  logic        last_max [2];

  // Staged inputs for the next cycle.
  logic        stg_sh   [2];
  logic        stg_ld   [2];
  logic [31:0] stg_seed [2];
  logic        stg_mode [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelMask(input int bits);
    return 32'((64'd1 << bits) - 64'd1);
  endfunction

  // Next state from the polynomial rules: Fibonacci feeds the parity of the
  // tapped bits into the bottom; Galois shifts left and folds the polynomial
  // back in whenever a one falls off the top.
  function automatic logic [31:0] modelNext(input int d, input logic [31:0] s, input logic gal);
    logic [31:0] r;
    int ones;
    r = (s << 1) & modelMask(m_w[d]);
    if (!gal) begin
      ones = 0;
      for (int i = 0; i < m_w[d]; i++)
        if (s[i] && m_taps[d][i]) ones++;
      r = r | 32'(ones % 2);
    end else if (s[m_w[d]-1]) begin
      r = r ^ m_poly[d];
    end
    return r;
  endfunction

  function automatic logic [31:0] satInc(input int d, input logic [31:0] v);
    return (v >= modelMask(m_cw[d])) ? modelMask(m_cw[d]) : v + 32'd1;
  endfunction

  function automatic exp_t modelStep(input int d);
    exp_t e;
    logic [31:0] n;
    e.max_tick = 1'b0;
    e.lockup   = 1'b0;
    if (stg_ld[d]) begin
      n = stg_seed[d] & modelMask(m_w[d]);
      if (n == 32'd0) begin
        n = m_seed[d];
        e.lockup = 1'b1;
      end
      m_q[d]     = n;
      m_start[d] = n;
      m_ticks[d] = 32'd0;
    end else if (stg_sh[d] && (stg_mode[d] != m_modeq[d])) begin
      m_start[d] = m_q[d];
      m_ticks[d] = 32'd0;
    end else if (stg_sh[d]) begin
      n = modelNext(d, m_q[d], m_modeq[d]);
      if (n == m_start[d]) begin
        m_period[d] = satInc(d, m_ticks[d]);
        m_ticks[d]  = 32'd0;
        e.max_tick  = 1'b1;
      end else begin
        m_ticks[d] = satInc(d, m_ticks[d]);
      end
      m_q[d] = n;
    end
    m_modeq[d] = stg_mode[d];
    e.q      = m_q[d];
    e.ticks  = m_ticks[d];
    e.period = m_period[d];
    return e;
  endfunction

  task automatic driveBuses();
    bus_a.sh_en   = stg_sh[0];
    bus_a.load    = stg_ld[0];
    bus_a.seed_in = stg_seed[0][15:0];
    bus_a.mode    = stg_mode[0];
    bus_b.sh_en   = stg_sh[1];
    bus_b.load    = stg_ld[1];
    bus_b.seed_in = stg_seed[1][3:0];
    bus_b.mode    = stg_mode[1];
  endtask

  // Called on a falling edge: drive, predict, queue, then wait a full cycle.
  task automatic runCycle();
    exp_t e;
    driveBuses();
    e = modelStep(0);
    exp_q0.push_back(e);
    last_max[0] = e.max_tick;
    e = modelStep(1);
    exp_q1.push_back(e);
    last_max[1] = e.max_tick;
    @(negedge clk);
  endtask

  // Stimulus for one instance; the other one idles with its mode held.
  task automatic applyStimulus(input int d, input logic sh, input logic ld,
                               input logic [31:0] seed, input logic md, input int n);
    stg_sh[d]   = sh;
    stg_ld[d]   = ld;
    stg_seed[d] = seed;
    stg_mode[d] = md;
    stg_sh[1-d] = 1'b0;
    stg_ld[1-d] = 1'b0;
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_a_q"},      32'(bus_a.q_out),    32'h1);
    checkOutput({tag, "_a_ticks"},  32'(bus_a.ticks),    32'h0);
    checkOutput({tag, "_a_period"}, 32'(bus_a.period),   32'h0);
    checkOutput({tag, "_a_max"},    32'(bus_a.max_tick), 32'h0);
    checkOutput({tag, "_a_lock"},   32'(bus_a.lockup),   32'h0);
    checkOutput({tag, "_b_q"},      32'(bus_b.q_out),    32'h1);
    checkOutput({tag, "_b_ticks"},  32'(bus_b.ticks),    32'h0);
    checkOutput({tag, "_b_period"}, 32'(bus_b.period),   32'h0);
    checkOutput({tag, "_b_max"},    32'(bus_b.max_tick), 32'h0);
    checkOutput({tag, "_b_lock"},   32'(bus_b.lockup),   32'h0);
  endtask

  // Assert reset now, optionally check that it took effect immediately, hold
  // for n falling edges, check again and release on a falling edge.
  task automatic applyReset(input int n, input logic check_now);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_q[d]      = m_seed[d];
      m_start[d]  = m_seed[d];
      m_ticks[d]  = 32'd0;
      m_period[d] = 32'd0;
      m_modeq[d]  = 1'b0;
      last_max[d] = 1'b0;
      stg_sh[d]   = 1'b0;
      stg_ld[d]   = 1'b0;
      stg_seed[d] = 32'd0;
      stg_mode[d] = 1'b0;
    end
    driveBuses();
    if (check_now) begin
      #1;
      checkResetValues("rst_immediate");
    end
    repeat (n) @(negedge clk);
    checkResetValues("rst_hold");
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per instance per rising edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q0.pop_front();
          checkOutput("a_q",      32'(bus_a.q_out),    e.q);
          checkOutput("a_ticks",  32'(bus_a.ticks),    e.ticks);
          checkOutput("a_period", 32'(bus_a.period),   e.period);
          checkOutput("a_max",    32'(bus_a.max_tick), 32'(e.max_tick));
          checkOutput("a_lock",   32'(bus_a.lockup),   32'(e.lockup));
          e = exp_q1.pop_front();
          checkOutput("b_q",      32'(bus_b.q_out),    e.q);
          checkOutput("b_ticks",  32'(bus_b.ticks),    e.ticks);
          checkOutput("b_period", 32'(bus_b.period),   e.period);
          checkOutput("b_max",    32'(bus_b.max_tick), 32'(e.max_tick));
          checkOutput("b_lock",   32'(bus_b.lockup),   32'(e.lockup));
        end
      end
    end
  end

  initial begin
    logic [31:0] b_start;
    logic        found;
    logic        md;
    rst_n = 1'b0;
    applyReset(5, 1'b0);

    // 16-bit Fibonacci: 0001 -> ... -> 0400 -> 0801 after 11 shifts.
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 11);
    checkOutput("fib16_q11",     32'(bus_a.q_out),    32'h0801);
    checkOutput("fib16_ticks11", 32'(bus_a.ticks),    32'd11);
    checkOutput("fib16_max",     32'(bus_a.max_tick), 32'd0);

    // 16-bit Galois from reset: switch cycle, then 16 shifts to 6801.
    applyReset(2, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("gal16_switch_q",     32'(bus_a.q_out), 32'h0001);
    checkOutput("gal16_switch_ticks", 32'(bus_a.ticks), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 16);
    checkOutput("gal16_q16",     32'(bus_a.q_out), 32'h6801);
    checkOutput("gal16_ticks16", 32'(bus_a.ticks), 32'd16);

    // Zero-seed load is replaced by SEED and flagged for one cycle.
    applyStimulus(0, 1'b0, 1'b1, 32'd0, 1'b1, 1);
    checkOutput("load0_q",    32'(bus_a.q_out),  32'h0001);
    checkOutput("load0_lock", 32'(bus_a.lockup), 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 3);
    checkOutput("load0_lock_gone", 32'(bus_a.lockup), 32'd0);
    checkOutput("load0_ticks3",    32'(bus_a.ticks),  32'd3);
    // Load wins over a concurrent shift.
    applyStimulus(0, 1'b1, 1'b1, 32'hACE1, 1'b1, 1);
    checkOutput("loadace1_q",      32'(bus_a.q_out),  32'hACE1);
    checkOutput("loadace1_ticks",  32'(bus_a.ticks),  32'd0);
    checkOutput("loadace1_period", 32'(bus_a.period), 32'd0);

    // 4-bit Fibonacci: full period of 15, two wraps.
    applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 15);
    checkOutput("fib4_wrap_q",      32'(bus_b.q_out),    32'h1);
    checkOutput("fib4_wrap_ticks",  32'(bus_b.ticks),    32'd0);
    checkOutput("fib4_wrap_period", 32'(bus_b.period),   32'd15);
    checkOutput("fib4_wrap_max",    32'(bus_b.max_tick), 32'd1);
    applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 22);

    // Toggle to Galois mid-run: no shift, re-arm at the current state.
    b_start = 32'(bus_b.q_out);
    applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("toggle_q",     32'(bus_b.q_out), b_start);
    checkOutput("toggle_ticks", 32'(bus_b.ticks), 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 15);
    checkOutput("gal4_wrap_q",      32'(bus_b.q_out),  b_start);
    checkOutput("gal4_wrap_period", 32'(bus_b.period), 32'd15);
    checkOutput("gal4_wrap_ticks",  32'(bus_b.ticks),  32'd0);

    // Randomised traffic on both instances against the model.
    md = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) md = ~md;
      applyStimulus(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, md, 1);
    end
    md = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) md = ~md;
      applyStimulus(1, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 24) == 0),
                    32'($urandom_range(0, 15)), md, 1);
    end

    // Reset while a wrap pulse is showing: immediate return, pulse dropped.
    applyStimulus(1, 1'b0, 1'b1, 32'h1, 1'b0, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 1);
      found = last_max[1];
    end
    checkOutput("midrst_wrap_seen", 32'(found), 32'd1);
    applyReset(3, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 1'b0, 3);
    checkOutput("midrst_after_max", 32'(bus_b.max_tick), 32'd0);
    checkOutput("midrst_after_q",   32'(bus_b.q_out),    32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
